// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one MAC per cycle over N-element rows for M neurons,
// then bias, arithmetic shift, saturation and optional ReLU per neuron.
module fc_layer_seq #(
   parameter int FLATTENED_LENGTH = 432,
   parameter int NUM_OUTPUTS      = 10,
   parameter int DATA_WIDTH       = 8,
   parameter int ACC_WIDTH        = 32,
   parameter int OUT_SHIFT        = 0,
   parameter int RELU_EN          = 0,
   localparam int FA_W = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1,
   localparam int WA_W = (FLATTENED_LENGTH * NUM_OUTPUTS > 1) ?
                         $clog2(FLATTENED_LENGTH * NUM_OUTPUTS) : 1,
   localparam int OI_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start,
   output logic                                          busy,
   output logic [FA_W-1:0]                               fmap_raddr,
   input  logic signed [DATA_WIDTH-1:0]                  fmap_rdata,
   output logic [WA_W-1:0]                               weight_raddr,
   input  logic signed [DATA_WIDTH-1:0]                  weight_rdata,
   input  logic signed [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] bias,
   output logic                                          out_valid,
   output logic [OI_W-1:0]                               out_index,
   output logic signed [DATA_WIDTH-1:0]                  out_data,
   output logic                                          done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT} state_t;

   localparam logic [FA_W-1:0] I_LAST     = FA_W'(FLATTENED_LENGTH - 1);
   localparam logic [OI_W-1:0] K_LAST     = OI_W'(NUM_OUTPUTS - 1);
   localparam logic [WA_W-1:0] ROW_STRIDE = WA_W'(FLATTENED_LENGTH);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   state_t state, state_nx;
   logic [FA_W-1:0] i_cnt;
   logic [OI_W-1:0] k_cnt;
   logic [WA_W-1:0] w_base;
   logic signed [ACC_WIDTH-1:0] acc, acc_bias, shifted;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [DATA_WIDTH-1:0] bias_k, sat_res, result;
   logic [0:0] vld_pipe;  // read data valid: previous cycle presented a RUN address
   logic accept, run, emit, last_i, last_k;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last_i) state_nx = S_DRAIN;
         S_DRAIN: state_nx = S_EMIT;
         S_EMIT:  state_nx = last_k ? S_IDLE : S_RUN;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != S_IDLE);
      accept = (state == S_IDLE) && start;
      run    = (state == S_RUN);
      emit   = (state == S_EMIT);
   end

   assign last_i       = (i_cnt == I_LAST);
   assign last_k       = (k_cnt == K_LAST);
   assign fmap_raddr   = i_cnt;
   assign weight_raddr = w_base + WA_W'(i_cnt);

   assign prod     = (2*DATA_WIDTH)'(fmap_rdata) * (2*DATA_WIDTH)'(weight_rdata);
   assign bias_k   = bias[k_cnt];
   assign acc_bias = acc + ACC_WIDTH'(bias_k);
   assign shifted  = acc_bias >>> OUT_SHIFT;

   always_comb begin
      if (shifted > SAT_MAX)      sat_res = SAT_MAX[DATA_WIDTH-1:0];
      else if (shifted < SAT_MIN) sat_res = SAT_MIN[DATA_WIDTH-1:0];
      else                        sat_res = shifted[DATA_WIDTH-1:0];
      result = ((RELU_EN != 0) && sat_res[DATA_WIDTH-1]) ? '0 : sat_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         i_cnt     <= '0;
         k_cnt     <= '0;
         w_base    <= '0;
         acc       <= '0;
         vld_pipe  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
      end else begin
         vld_pipe  <= run;
         out_valid <= 1'b0;
         done      <= 1'b0;
         if (accept) begin
            i_cnt  <= '0;
            k_cnt  <= '0;
            w_base <= '0;
            acc    <= '0;
         end else if (vld_pipe[0]) begin
            acc <= acc + ACC_WIDTH'(prod);
         end
         if (run && !last_i) i_cnt <= i_cnt + FA_W'(1);
         if (emit) begin
            out_valid <= 1'b1;
            out_index <= k_cnt;
            out_data  <= result;
            acc       <= '0;
            i_cnt     <= '0;
            if (last_k) begin
               done   <= 1'b1;
               k_cnt  <= '0;
               w_base <= '0;
            end else begin
               k_cnt  <= k_cnt + OI_W'(1);
               w_base <= w_base + ROW_STRIDE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: table vectors on N=4/M=2 variants, N=1/M=1 corner,
// handshake/reset sequences and a randomized N=432/M=10 run against an arithmetic model.
module tb_fc_layer_seq;

   typedef logic signed [7:0] s8;
   typedef struct { int k; int d; int c; } ev_t;
   typedef struct {
      s8 [3:0] f;
      s8 [7:0] w;  // element k*4+i
      s8 [1:0] b;
      int a0, a1, r0, r1, s0, s1;  // plain, relu, shift-by-2 expectations
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start4, start1, starte;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;

   // shared memories for the three N=4,M=2 instances
   s8 fmem [4];
   s8 wmem [8];
   logic signed [1:0][7:0] bias4;
   s8 fmem_d [1];
   s8 wmem_d [1];
   logic signed [0:0][7:0] bias_d;
   s8 fmem_e [432];
   s8 wmem_e [4320];
   logic signed [9:0][7:0] bias_e;

   logic a_busy, a_ov, a_done, b_busy, b_ov, b_done, c_busy, c_ov, c_done;
   logic [1:0] a_fa, b_fa, c_fa;
   logic [2:0] a_wa, b_wa, c_wa;
   logic [0:0] a_oi, b_oi, c_oi;
   logic signed [7:0] a_fr, a_wr, a_od, b_fr, b_wr, b_od, c_fr, c_wr, c_od;
   logic d_busy, d_ov, d_done;
   logic [0:0] d_fa, d_wa, d_oi;
   logic signed [7:0] d_fr, d_wr, d_od;
   logic e_busy, e_ov, e_done;
   logic [8:0] e_fa;
   logic [12:0] e_wa;
   logic [3:0] e_oi;
   logic signed [7:0] e_fr, e_wr, e_od;

   fc_layer_seq #(.FLATTENED_LENGTH(4), .NUM_OUTPUTS(2), .DATA_WIDTH(8), .ACC_WIDTH(32),
                  .OUT_SHIFT(0), .RELU_EN(0)) ua (
      .clk(clk), .reset(rst), .start(start4), .busy(a_busy), .fmap_raddr(a_fa),
      .fmap_rdata(a_fr), .weight_raddr(a_wa), .weight_rdata(a_wr), .bias(bias4),
      .out_valid(a_ov), .out_index(a_oi), .out_data(a_od), .done(a_done));
   fc_layer_seq #(.FLATTENED_LENGTH(4), .NUM_OUTPUTS(2), .DATA_WIDTH(8), .ACC_WIDTH(32),
                  .OUT_SHIFT(0), .RELU_EN(1)) ub (
      .clk(clk), .reset(rst), .start(start4), .busy(b_busy), .fmap_raddr(b_fa),
      .fmap_rdata(b_fr), .weight_raddr(b_wa), .weight_rdata(b_wr), .bias(bias4),
      .out_valid(b_ov), .out_index(b_oi), .out_data(b_od), .done(b_done));
   fc_layer_seq #(.FLATTENED_LENGTH(4), .NUM_OUTPUTS(2), .DATA_WIDTH(8), .ACC_WIDTH(32),
                  .OUT_SHIFT(2), .RELU_EN(0)) uc (
      .clk(clk), .reset(rst), .start(start4), .busy(c_busy), .fmap_raddr(c_fa),
      .fmap_rdata(c_fr), .weight_raddr(c_wa), .weight_rdata(c_wr), .bias(bias4),
      .out_valid(c_ov), .out_index(c_oi), .out_data(c_od), .done(c_done));
   fc_layer_seq #(.FLATTENED_LENGTH(1), .NUM_OUTPUTS(1), .DATA_WIDTH(8), .ACC_WIDTH(32),
                  .OUT_SHIFT(0), .RELU_EN(0)) ud (
      .clk(clk), .reset(rst), .start(start1), .busy(d_busy), .fmap_raddr(d_fa),
      .fmap_rdata(d_fr), .weight_raddr(d_wa), .weight_rdata(d_wr), .bias(bias_d),
      .out_valid(d_ov), .out_index(d_oi), .out_data(d_od), .done(d_done));
   fc_layer_seq #(.FLATTENED_LENGTH(432), .NUM_OUTPUTS(10), .DATA_WIDTH(8), .ACC_WIDTH(32),
                  .OUT_SHIFT(0), .RELU_EN(0)) ue (
      .clk(clk), .reset(rst), .start(starte), .busy(e_busy), .fmap_raddr(e_fa),
      .fmap_rdata(e_fr), .weight_raddr(e_wa), .weight_rdata(e_wr), .bias(bias_e),
      .out_valid(e_ov), .out_index(e_oi), .out_data(e_od), .done(e_done));

   // synchronous read ports, latency 1
   always @(posedge clk) begin
      a_fr <= fmem[a_fa];  a_wr <= wmem[a_wa];
      b_fr <= fmem[b_fa];  b_wr <= wmem[b_wa];
      c_fr <= fmem[c_fa];  c_wr <= wmem[c_wa];
      d_fr <= fmem_d[d_fa]; d_wr <= wmem_d[d_wa];
      e_fr <= fmem_e[e_fa]; e_wr <= wmem_e[e_wa];
   end

   ev_t qa[$], qb[$], qc[$], qd[$], qe[$];
   int da[$], dd[$], de[$];
   always @(negedge clk) begin
      if (a_ov) qa.push_back(ev_t'{int'(a_oi), int'(a_od), cyc});
      if (b_ov) qb.push_back(ev_t'{int'(b_oi), int'(b_od), cyc});
      if (c_ov) qc.push_back(ev_t'{int'(c_oi), int'(c_od), cyc});
      if (d_ov) qd.push_back(ev_t'{int'(d_oi), int'(d_od), cyc});
      if (e_ov) qe.push_back(ev_t'{int'(e_oi), int'(e_od), cyc});
      if (a_done) da.push_back(cyc);
      if (d_done) dd.push_back(cyc);
      if (e_done) de.push_back(cyc);
   end

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // reference: wrap to 32-bit accumulator, floor shift, clamp to int8, optional ReLU
   function automatic int ref_out(input longint s, input int sh, input int relu);
      longint r;
      r = longint'(int'(s)) >>> sh;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      if (relu != 0 && r < 0) r = 0;
      return int'(r);
   endfunction

   function automatic int model4(input vec_t v, input int k, input int sh, input int relu);
      longint s = 0;
      for (int i = 0; i < 4; i++)
         s += longint'($signed(v.f[i])) * longint'($signed(v.w[k*4+i]));
      s += longint'($signed(v.b[k]));
      return ref_out(s, sh, relu);
   endfunction

   task automatic load4(input vec_t v);
      for (int i = 0; i < 4; i++) fmem[i] = v.f[i];
      for (int i = 0; i < 8; i++) wmem[i] = v.w[i];
      bias4 = v.b;
   endtask

   task automatic cmp_q(input string name, input int sel, input int e0, input int e1,
                        input int c0);
      ev_t q[$];
      case (sel)
         0: q = qa;
         1: q = qb;
         default: q = qc;
      endcase
      check({name, "_count"}, q.size(), 2);
      for (int j = 0; j < 2 && j < q.size(); j++) begin
         check($sformatf("%s_n%0d_index", name, j), q[j].k, j);
         check($sformatf("%s_n%0d_data", name, j), q[j].d, (j == 0) ? e0 : e1);
         check($sformatf("%s_n%0d_cycle", name, j), q[j].c, c0 + (j + 1) * 6);
      end
   endtask

   task automatic clear_q();
      qa.delete(); qb.delete(); qc.delete(); da.delete();
   endtask

   task automatic run4(input vec_t v, input string tag);
      int c0;
      load4(v);
      clear_q();
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      c0 = cyc;
      to_cyc(c0 + 11);
      check({tag, "_busy_before_done"}, a_busy, 1);
      to_cyc(c0 + 12);
      check({tag, "_busy_low_at_done"}, a_busy, 0);
      to_cyc(c0 + 14);
      cmp_q({tag, "_plain"}, 0, v.a0, v.a1, c0);
      cmp_q({tag, "_relu"}, 1, v.r0, v.r1, c0);
      cmp_q({tag, "_shift2"}, 2, v.s0, v.s1, c0);
      check({tag, "_done_count"}, da.size(), 1);
      if (da.size() > 0) check({tag, "_done_cycle"}, da[0], c0 + 12);
   endtask

   task automatic run1(input int f, input int w, input int b, input int exp, input string tag);
      int c0;
      fmem_d[0] = s8'(f); wmem_d[0] = s8'(w); bias_d = s8'(b);
      qd.delete(); dd.delete();
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      c0 = cyc;
      check({tag, "_addr"}, {d_fa, d_wa}, 0);
      to_cyc(c0 + 5);
      check({tag, "_count"}, qd.size(), 1);
      if (qd.size() > 0) begin
         check({tag, "_index"}, qd[0].k, 0);
         check({tag, "_data"}, qd[0].d, exp);
         check({tag, "_cycle"}, qd[0].c, c0 + 3);
      end
      check({tag, "_done_count"}, dd.size(), 1);
      if (dd.size() > 0) check({tag, "_done_cycle"}, dd[0], c0 + 3);
   endtask

   vec_t tbl[10];

   initial begin
      int c0, aerr;
      longint s;
      rst = 1'b1; start4 = 1'b0; start1 = 1'b0; starte = 1'b0;
      foreach (fmem[i]) fmem[i] = '0;
      foreach (wmem[i]) wmem[i] = '0;
      bias4 = '0; bias_d = '0; bias_e = '0;
      fmem_d[0] = '0; wmem_d[0] = '0;

      // fixed vectors: basic, saturation, bias-only, floor of small negatives
      tbl[0].f = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
      tbl[0].w = {-8'sd4, -8'sd3, -8'sd2, -8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
      tbl[0].b = {-8'sd3, 8'sd5};
      tbl[0].a0 = 15;  tbl[0].a1 = -33;  tbl[0].r0 = 15;  tbl[0].r1 = 0;
      tbl[0].s0 = 3;   tbl[0].s1 = -9;
      tbl[1].f = {4{8'sd127}};
      tbl[1].w = {{4{8'h80}}, {4{8'sd127}}};
      tbl[1].b = '0;
      tbl[1].a0 = 127; tbl[1].a1 = -128; tbl[1].r0 = 127; tbl[1].r1 = 0;
      tbl[1].s0 = 127; tbl[1].s1 = -128;
      tbl[2].f = '0;
      tbl[2].w = {8{8'sd9}};
      tbl[2].b = {8'sd100, -8'sd7};
      tbl[2].a0 = -7;  tbl[2].a1 = 100;  tbl[2].r0 = 0;   tbl[2].r1 = 100;
      tbl[2].s0 = -2;  tbl[2].s1 = 25;
      tbl[3].f = {8'sd0, 8'sd0, 8'sd0, 8'sd1};
      tbl[3].w = {{4{8'sd5}}, {4{-8'sd1}}};
      tbl[3].b = '0;
      tbl[3].a0 = -1;  tbl[3].a1 = 5;    tbl[3].r0 = 0;   tbl[3].r1 = 5;
      tbl[3].s0 = -1;  tbl[3].s1 = 1;
      for (int t = 4; t < 10; t++) begin
         for (int i = 0; i < 4; i++) tbl[t].f[i] = s8'($urandom);
         for (int i = 0; i < 8; i++) tbl[t].w[i] = s8'($urandom_range(0, 40) - 20);
         for (int i = 0; i < 2; i++) tbl[t].b[i] = s8'($urandom);
         tbl[t].a0 = model4(tbl[t], 0, 0, 0); tbl[t].a1 = model4(tbl[t], 1, 0, 0);
         tbl[t].r0 = model4(tbl[t], 0, 0, 1); tbl[t].r1 = model4(tbl[t], 1, 0, 1);
         tbl[t].s0 = model4(tbl[t], 0, 2, 0); tbl[t].s1 = model4(tbl[t], 1, 2, 0);
      end

      repeat (3) @(negedge clk);
      check("reset_busy", a_busy, 0);
      check("reset_out_valid", a_ov, 0);
      check("reset_done", a_done, 0);
      check("reset_out_index", a_oi, 0);
      check("reset_out_data", a_od, 0);
      check("reset_fmap_raddr", a_fa, 0);
      check("reset_weight_raddr", a_wa, 0);
      check("reset_big_addr", {e_fa, e_wa}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 10; t++) run4(tbl[t], $sformatf("vec%0d", t));

      // start pulses while busy must be ignored
      load4(tbl[0]); clear_q();
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      c0 = cyc;
      to_cyc(c0 + 4); start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      to_cyc(c0 + 9); start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      to_cyc(c0 + 30);
      cmp_q("busy_start", 0, 15, -33, c0);
      check("busy_start_done_count", da.size(), 1);
      check("busy_start_idle", a_busy, 0);

      // start held high: back-to-back runs with one idle cycle between
      clear_q();
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) c0 = cyc;
      to_cyc(c0 + 12);
      check("hold_done", a_done, 1);
      check("hold_busy_low", a_busy, 0);
      @(negedge clk);
      check("hold_rerun_busy", a_busy, 1);
      start4 = 1'b0;
      to_cyc(c0 + 28);
      check("hold_out_count", qa.size(), 4);
      if (qa.size() == 4) begin
         check("hold_second_k0_cycle", qa[2].c, c0 + 13 + 6);
         check("hold_second_k0_data", qa[2].d, 15);
         check("hold_second_k1_data", qa[3].d, -33);
      end
      check("hold_done_count", da.size(), 2);
      if (da.size() == 2) check("hold_second_done_cycle", da[1], c0 + 25);

      // reset during neuron 1 RUN aborts the run
      load4(tbl[0]); clear_q();
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      c0 = cyc;
      to_cyc(c0 + 7);
      check("midreset_first_out", qa.size(), 1);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_busy", a_busy, 0);
      check("midreset_out_valid", a_ov, 0);
      check("midreset_done", a_done, 0);
      check("midreset_out_data", a_od, 0);
      check("midreset_out_index", a_oi, 0);
      check("midreset_addr", {a_fa, a_wa}, 0);
      rst = 1'b0;
      to_cyc(c0 + 30);
      check("midreset_no_more_out", qa.size(), 1);
      check("midreset_no_done", da.size(), 0);
      run4(tbl[0], "after_reset");

      // N=1, M=1 corner
      run1(5, -3, 2, -13, "n1_basic");
      run1(127, 127, 0, 127, "n1_sat_hi");
      run1(-128, 127, -128, -128, "n1_sat_lo");
      for (int t = 0; t < 3; t++) begin
         int f, w, b;
         f = $urandom_range(0, 255) - 128;
         w = $urandom_range(0, 255) - 128;
         b = $urandom_range(0, 255) - 128;
         run1(f, w, b, ref_out(longint'(f * w + b), 0, 0), $sformatf("n1_rand%0d", t));
      end

      // full-size randomized run with per-cycle address scoreboard
      foreach (fmem_e[i]) fmem_e[i] = s8'($urandom);
      foreach (wmem_e[i]) wmem_e[i] = s8'($urandom);
      for (int k = 0; k < 10; k++) bias_e[k] = s8'($urandom);
      qe.delete(); de.delete();
      aerr = 0;
      @(negedge clk) starte = 1'b1;
      @(negedge clk) starte = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 434; j++) begin
            if (j < 432) begin
               if (int'(e_fa) != j || int'(e_wa) != k * 432 + j) aerr++;
            end else if (int'(e_fa) >= 432 || int'(e_wa) >= 4320) begin
               aerr++;
            end
            @(negedge clk);
         end
      end
      @(negedge clk);
      check("big_addr_errors", aerr, 0);
      check("big_out_count", qe.size(), 10);
      for (int k = 0; k < 10 && k < qe.size(); k++) begin
         s = 0;
         for (int i = 0; i < 432; i++)
            s += longint'(fmem_e[i]) * longint'(wmem_e[k*432+i]);
         s += longint'($signed(bias_e[k]));
         check($sformatf("big_n%0d_index", k), qe[k].k, k);
         check($sformatf("big_n%0d_data", k), qe[k].d, ref_out(s, 0, 0));
         check($sformatf("big_n%0d_cycle", k), qe[k].c, c0 + (k + 1) * 434);
      end
      check("big_done_count", de.size(), 1);
      if (de.size() > 0) check("big_done_cycle", de[0], c0 + 4340);
      check("big_busy_end", e_busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
